// File: rtl/time_set_controller.sv
// time_set_controller: 24-hour hh:mm:ss register with a button-driven edit FSM.
// In RUN the time advances on tick_1hz. In the three SET states it is frozen,
// the selected field is stepped by ADJ events, and an inactivity timeout
// returns to RUN. Every output comes straight from a flop.
module time_set_controller #(
    parameter int unsigned TIMEOUT_S = 10   // edit inactivity timeout in ticks, 1..63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [1:0] mode_evt,
    input  logic [1:0] adj_evt,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] field_sel,
    output logic       blink
);

    // The state encoding is the field_sel value, so field_sel is the state flop itself.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } state_t;

    localparam logic [1:0] EVT_NONE  = 2'd0;
    localparam logic [1:0] EVT_SHORT = 2'd1;
    localparam logic [1:0] EVT_LONG  = 2'd2;

    // The timeout fires on the tick that would bring the counter to TIMEOUT_S.
    localparam logic [5:0] TO_LAST = 6'(TIMEOUT_S - 1);

    state_t     state, state_n;
    logic [4:0] hours_n;
    logic [5:0] minutes_n, seconds_n;
    logic       blink_n;
    logic [5:0] to_cnt, to_cnt_n;
    logic [1:0] mode, adj;

    // Wrapping step helpers; no carry or borrow leaves these functions.
    function automatic logic [4:0] hr_inc(input logic [4:0] h);
        return (h >= 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    function automatic logic [4:0] hr_dec(input logic [4:0] h);
        return (h == 5'd0 || h > 5'd23) ? 5'd23 : h - 5'd1;
    endfunction

    function automatic logic [5:0] ms_inc(input logic [5:0] v);
        return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] ms_dec(input logic [5:0] v);
        return (v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1;
    endfunction

    // Code 3 from either detector is not a valid event; fold it to "none".
    always_comb begin
        mode = (mode_evt == 2'd3) ? EVT_NONE : mode_evt;
        adj  = (adj_evt  == 2'd3) ? EVT_NONE : adj_evt;
    end

    // Next-state, time, blink and timeout logic. Priority in SET states is
    // mode event, then adj event, then tick; a mode event swallows a
    // coincident adj event and a coincident tick.
    always_comb begin
        state_n   = state;
        hours_n   = hours;
        minutes_n = minutes;
        seconds_n = seconds;
        blink_n   = blink;
        to_cnt_n  = to_cnt;

        case (state)
            RUN: begin
                blink_n  = 1'b0;
                to_cnt_n = 6'd0;
                if (mode == EVT_SHORT) begin
                    // Entering edit drops any coincident tick.
                    state_n = SET_HR;
                end else if (tick_1hz) begin
                    if (seconds >= 6'd59) begin
                        seconds_n = 6'd0;
                        if (minutes >= 6'd59) begin
                            minutes_n = 6'd0;
                            hours_n   = hr_inc(hours);
                        end else begin
                            minutes_n = minutes + 6'd1;
                        end
                    end else begin
                        seconds_n = seconds + 6'd1;
                    end
                end
            end

            default: begin
                if (mode != EVT_NONE) begin
                    to_cnt_n = 6'd0;
                    blink_n  = 1'b0;
                    if (mode == EVT_LONG) begin
                        state_n = RUN;
                    end else begin
                        case (state)
                            SET_HR:  state_n = SET_MIN;
                            SET_MIN: state_n = SET_SEC;
                            default: state_n = RUN;
                        endcase
                    end
                end else if (adj != EVT_NONE) begin
                    to_cnt_n = 6'd0;
                    blink_n  = 1'b0;
                    case (state)
                        SET_HR:  hours_n   = (adj == EVT_SHORT) ? hr_inc(hours)   : hr_dec(hours);
                        SET_MIN: minutes_n = (adj == EVT_SHORT) ? ms_inc(minutes) : ms_dec(minutes);
                        default: seconds_n = (adj == EVT_SHORT) ? ms_inc(seconds) : ms_dec(seconds);
                    endcase
                end else if (tick_1hz) begin
                    if (to_cnt >= TO_LAST) begin
                        state_n  = RUN;
                        to_cnt_n = 6'd0;
                        blink_n  = 1'b0;
                    end else begin
                        to_cnt_n = to_cnt + 6'd1;
                        blink_n  = ~blink;
                    end
                end
            end
        endcase
    end

    // State, time fields, blink phase and timeout counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            hours   <= 5'd0;
            minutes <= 6'd0;
            seconds <= 6'd0;
            blink   <= 1'b0;
            to_cnt  <= 6'd0;
        end else begin
            state   <= state_n;
            hours   <= hours_n;
            minutes <= minutes_n;
            seconds <= seconds_n;
            blink   <= blink_n;
            to_cnt  <= to_cnt_n;
        end
    end

    assign field_sel = state;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller: a vector table for single-cycle
// behaviour plus hand-written sequences for counting, timeout and reset.
module tb_time_set_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic [1:0] mode_evt;
    logic [1:0] adj_evt;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] field_sel;
    logic       blink;

    int n_vec = 0;
    int n_err = 0;

    time_set_controller #(.TIMEOUT_S(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_1hz  (tick_1hz),
        .mode_evt  (mode_evt),
        .adj_evt   (adj_evt),
        .hours     (hours),
        .minutes   (minutes),
        .seconds   (seconds),
        .field_sel (field_sel),
        .blink     (blink)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [1:0] adj;
        logic       tick;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] f;
        logic       b;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [1:0] mode, input logic [1:0] adj, input logic tick,
                       input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                       input logic [1:0] f, input logic b);
        vec_t v;
        v.mode = mode; v.adj = adj; v.tick = tick;
        v.h = h; v.m = m; v.s = s; v.f = f; v.b = b;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [4:0] h, input logic [5:0] m,
                         input logic [5:0] s, input logic [1:0] f, input logic b);
        n_vec++;
        if (hours !== h || minutes !== m || seconds !== s || field_sel !== f || blink !== b) begin
            n_err++;
            $display("FAIL %s: got %0d:%0d:%0d f=%0d b=%0d, expected %0d:%0d:%0d f=%0d b=%0d",
                     name, hours, minutes, seconds, field_sel, blink, h, m, s, f, b);
        end
    endtask

    // One clock with the given events; events are one clk wide.
    task automatic step(input logic [1:0] mode, input logic [1:0] adj, input logic tick);
        @(negedge clk);
        mode_evt = mode; adj_evt = adj; tick_1hz = tick;
        @(posedge clk);
        #1;
        mode_evt = 2'd0; adj_evt = 2'd0; tick_1hz = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset", 5'd0, 6'd0, 6'd0, 2'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick_1hz = 1'b0; mode_evt = 2'd0; adj_evt = 2'd0;
        repeat (2) @(posedge clk);

        // Counting with carries: 3661 ticks -> 01:01:01.
        do_reset();
        for (int i = 1; i <= 3661; i++) begin
            step(2'd0, 2'd0, 1'b1);
            if (i == 59)   check("cnt_59",   5'd0, 6'd0, 6'd59, 2'd0, 1'b0);
            if (i == 60)   check("cnt_60",   5'd0, 6'd1, 6'd0,  2'd0, 1'b0);
            if (i == 3600) check("cnt_3600", 5'd1, 6'd0, 6'd0,  2'd0, 1'b0);
        end
        check("cnt_3661", 5'd1, 6'd1, 6'd1, 2'd0, 1'b0);

        // Vector table, starting from reset.
        //   mode   adj    tick  h      m      s      f     b
        add(2'd0, 2'd0, 1'b0, 5'd0,  6'd0,  6'd0,  2'd0, 1'b0); // idle after reset
        add(2'd0, 2'd0, 1'b1, 5'd0,  6'd0,  6'd1,  2'd0, 1'b0); // run tick
        add(2'd2, 2'd0, 1'b0, 5'd0,  6'd0,  6'd1,  2'd0, 1'b0); // long mode ignored in RUN
        add(2'd0, 2'd1, 1'b0, 5'd0,  6'd0,  6'd1,  2'd0, 1'b0); // adj ignored in RUN
        add(2'd1, 2'd0, 1'b1, 5'd0,  6'd0,  6'd1,  2'd1, 1'b0); // enter SET_HR, tick dropped
        add(2'd0, 2'd2, 1'b0, 5'd23, 6'd0,  6'd1,  2'd1, 1'b0); // hr 0 -> 23
        add(2'd0, 2'd1, 1'b0, 5'd0,  6'd0,  6'd1,  2'd1, 1'b0); // hr 23 -> 0
        add(2'd0, 2'd0, 1'b1, 5'd0,  6'd0,  6'd1,  2'd1, 1'b1); // tick frozen, blink
        add(2'd0, 2'd0, 1'b1, 5'd0,  6'd0,  6'd1,  2'd1, 1'b0);
        add(2'd0, 2'd0, 1'b1, 5'd0,  6'd0,  6'd1,  2'd1, 1'b1);
        add(2'd0, 2'd2, 1'b0, 5'd23, 6'd0,  6'd1,  2'd1, 1'b0); // adj clears blink
        add(2'd1, 2'd1, 1'b0, 5'd23, 6'd0,  6'd1,  2'd2, 1'b0); // mode wins, adj dropped
        add(2'd0, 2'd2, 1'b0, 5'd23, 6'd59, 6'd1,  2'd2, 1'b0); // min 0 -> 59
        add(2'd0, 2'd1, 1'b0, 5'd23, 6'd0,  6'd1,  2'd2, 1'b0); // min 59 -> 0, no carry
        add(2'd0, 2'd2, 1'b0, 5'd23, 6'd59, 6'd1,  2'd2, 1'b0);
        add(2'd1, 2'd0, 1'b0, 5'd23, 6'd59, 6'd1,  2'd3, 1'b0); // SET_SEC, secs kept
        add(2'd0, 2'd2, 1'b0, 5'd23, 6'd59, 6'd0,  2'd3, 1'b0);
        add(2'd0, 2'd2, 1'b0, 5'd23, 6'd59, 6'd59, 2'd3, 1'b0); // sec 0 -> 59
        add(2'd3, 2'd0, 1'b1, 5'd23, 6'd59, 6'd59, 2'd3, 1'b1); // mode 3 = none
        add(2'd0, 2'd3, 1'b1, 5'd23, 6'd59, 6'd59, 2'd3, 1'b0); // adj 3 = none
        add(2'd1, 2'd0, 1'b0, 5'd23, 6'd59, 6'd59, 2'd0, 1'b0); // back to RUN
        add(2'd0, 2'd0, 1'b1, 5'd0,  6'd0,  6'd0,  2'd0, 1'b0); // 23:59:59 wraps
        add(2'd0, 2'd0, 1'b1, 5'd0,  6'd0,  6'd1,  2'd0, 1'b0);
        add(2'd1, 2'd0, 1'b0, 5'd0,  6'd0,  6'd1,  2'd1, 1'b0);
        add(2'd1, 2'd0, 1'b0, 5'd0,  6'd0,  6'd1,  2'd2, 1'b0);
        add(2'd0, 2'd1, 1'b0, 5'd0,  6'd1,  6'd1,  2'd2, 1'b0);
        add(2'd2, 2'd0, 1'b0, 5'd0,  6'd1,  6'd1,  2'd0, 1'b0); // long mode commits
        add(2'd0, 2'd0, 1'b1, 5'd0,  6'd1,  6'd2,  2'd0, 1'b0); // counting resumes

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].mode, tbl[i].adj, tbl[i].tick);
            check($sformatf("vec%0d", i), tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].f, tbl[i].b);
        end

        // Timeout in SET_SEC, restarted by an adj event after 9 ticks.
        do_reset();
        step(2'd1, 2'd0, 1'b0);
        step(2'd1, 2'd0, 1'b0);
        step(2'd1, 2'd0, 1'b0);
        check("to_enter", 5'd0, 6'd0, 6'd0, 2'd3, 1'b0);
        repeat (9) step(2'd0, 2'd0, 1'b1);
        check("to_tick9", 5'd0, 6'd0, 6'd0, 2'd3, 1'b1);
        step(2'd0, 2'd1, 1'b0);
        check("to_adj", 5'd0, 6'd0, 6'd1, 2'd3, 1'b0);
        repeat (9) step(2'd0, 2'd0, 1'b1);
        check("to_restart9", 5'd0, 6'd0, 6'd1, 2'd3, 1'b1);
        step(2'd0, 2'd0, 1'b1);
        check("to_expire", 5'd0, 6'd0, 6'd1, 2'd0, 1'b0);
        step(2'd0, 2'd0, 1'b1);
        check("to_run", 5'd0, 6'd0, 6'd2, 2'd0, 1'b0);

        // Asynchronous reset mid-edit discards the partial edit.
        step(2'd1, 2'd0, 1'b0);
        step(2'd0, 2'd2, 1'b0);
        step(2'd0, 2'd0, 1'b1);
        check("edit_pre", 5'd23, 6'd0, 6'd2, 2'd1, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst", 5'd0, 6'd0, 6'd0, 2'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step(2'd0, 2'd0, 1'b0);
        check("post_rst", 5'd0, 6'd0, 6'd0, 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
